// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub
// Description : Bit-serial unsigned subtractor. Computes a-b LSB first, one bit
//               per clock, with a registered difference and final borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int               CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bin;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_ai;
    logic             w_bi;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_nxt;

    // A new operation may only start from IDLE or DONE; start in RUN is dropped.
    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last    = (r_cnt == c_LAST_BIT);

    assign w_ai      = r_a[0];
    assign w_bi      = r_b[0];
    assign w_d       = w_ai ^ w_bi ^ r_bin;
    assign w_bout    = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bin);
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: operand shifters, borrow chain, result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_bin    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_res <= '0;
            r_bin <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= {1'b0, r_a[WIDTH-1:1]};
            r_b   <= {1'b0, r_b[WIDTH-1:1]};
            r_res <= w_res_nxt;
            r_bin <= w_bout;
            r_cnt <= r_cnt + 1'b1;
            // Visible result only moves on the completion edge.
            if (w_last) begin
                r_diff   <= w_res_nxt;
                r_borrow <= w_bout;
            end
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub
// Description : Directed and random self-checking bench for serial_sub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;

    logic [W:0] sb[$];

    serial_sub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [W-1:0] x, input logic [W-1:0] y);
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back({1'b0, x} - {1'b0, y});
    endtask

    task automatic wait_done(input string tag);
        int   i;
        logic seen;
        seen = 1'b0;
        for (i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $error("FAIL %s_timeout: observed no done, expected done within 20 cycles", tag);
        end
    endtask

    // Scoreboard: every done pulse pops and checks one expected result.
    always @(negedge clk) begin
        logic [W:0] e;
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL sb_empty: observed done with result %0h, expected no done", {borrow, diff});
            end else begin
                e = sb.pop_front();
                chk("result", int'({borrow, diff}), int'(e));
            end
        end
    end

    logic [W-1:0] t_a[5]  = '{8'h03, 8'h00, 8'h00, 8'hA5, 8'hFF};
    logic [W-1:0] t_b[5]  = '{8'h05, 8'hFF, 8'h00, 8'hA5, 8'h00};
    logic [W:0]   t_e[5]  = '{9'h1FE, 9'h101, 9'h000, 9'h000, 9'h0FF};

    initial begin
        int n0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_borrow", int'(borrow), 0);
        rst = 1'b0;

        // Basic subtraction with exact cycle timing
        go(8'h05, 8'h03);
        tick();
        start = 1'b0;
        chk("basic_busy0", int'(busy), 1);
        chk("basic_done0", int'(done), 0);
        for (int i = 1; i < W; i++) begin
            tick();
            chk("basic_busy_run", int'({busy, done}), 2);
        end
        tick();
        chk("basic_done", int'(done), 1);
        chk("basic_busy_end", int'(busy), 0);
        chk("basic_res", int'({borrow, diff}), 9'h002);
        tick();
        chk("basic_done_fall", int'(done), 0);
        chk("basic_hold_idle", int'({borrow, diff}), 9'h002);

        // Borrow and boundary operand cases
        for (int i = 0; i < 5; i++) begin
            go(t_a[i], t_b[i]);
            tick();
            start = 1'b0;
            wait_done("table");
            chk("table_res", int'({borrow, diff}), int'(t_e[i]));
            tick();
        end

        // Start ignored while busy; result held during run
        n0 = n_done;
        go(8'h10, 8'h01);
        tick();
        start = 1'b0;
        chk("hold_in_run", int'({borrow, diff}), 9'h0FF);
        a = 8'hEE;
        b = 8'h77;
        tick();
        tick();
        start = 1'b1;
        a = 8'h00;
        b = 8'h01;
        tick();
        start = 1'b0;
        chk("ignored_busy", int'(busy), 1);
        wait_done("ignore");
        chk("ignore_res", int'({borrow, diff}), 9'h00F);
        repeat (12) tick();
        chk("ignore_one_done", n_done - n0, 1);

        // Reset in the middle of a run
        n0 = n_done;
        go(8'h77, 8'h11);
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        void'(sb.pop_back());
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_res", int'({borrow, diff}), 0);
        rst = 1'b0;
        repeat (12) tick();
        chk("abort_no_done", n_done - n0, 0);

        // Back-to-back random pairs, start held in the DONE cycle
        n0 = n_done;
        go(W'($urandom), W'($urandom));
        for (int i = 0; i < 1000; i++) begin
            tick();
            start = 1'b0;
            chk("b2b_busy", int'({busy, done}), 2);
            for (int j = 1; j < W; j++) tick();
            tick();
            chk("b2b_done", int'({busy, done}), 1);
            if (i < 999) go(W'($urandom), W'($urandom));
        end
        tick();
        chk("b2b_idle", int'({busy, done}), 0);
        chk("b2b_count", n_done - n0, 1000);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
